// File: rtl/mms_stream_8num.sv
// Streaming max/min reducer: folds each group of N unsigned numbers into one
// result presented on a valid/ready output port.
//
// state | meaning
// IDLE  | waiting for the first number of a group
// ACC   | folding numbers 2..N into the running max/min
// HOLD  | group result presented, waiting for the consumer
module mms_stream_8num #(
    parameter int DW = 8,
    parameter int N  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          select,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result,
    output logic          group_sel
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] acc, acc_nxt, acc_upd, result_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          sel_q, sel_nxt, gsel_nxt;
    logic          take;

    // Strict compare so ties keep the value already held.
    assign take    = sel_q ? (in_data < acc) : (in_data > acc);
    assign acc_upd = take ? in_data : acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sel_q     <= 1'b0;
            result    <= '0;
            group_sel <= 1'b0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            count     <= count_nxt;
            sel_q     <= sel_nxt;
            result    <= result_nxt;
            group_sel <= gsel_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        count_nxt  = count;
        sel_nxt    = sel_q;
        result_nxt = result;
        gsel_nxt   = group_sel;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt   = in_data;
                    sel_nxt   = select;
                    count_nxt = CW'(1);
                    state_nxt = ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_nxt   = acc_upd;
                    count_nxt = count + CW'(1);
                    if (count == LAST) begin
                        result_nxt = acc_upd;
                        gsel_nxt   = sel_q;
                        state_nxt  = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Nothing is accepted while reset is held.
        if (reset) in_ready = 1'b0;
    end

endmodule
